// File: rtl/eth_tx_sched_encap.sv
// eth_tx_sched_encap: round-robin channel scheduler and Ethernet framer (preamble..FCS, IFG) driving GMII TX.
// Build option: define TX_VLAN_EN to insert an 802.1Q tag built from VLAN_TCI after the source MAC.
module eth_tx_sched_encap #(
    parameter int          N_CH      = 2,
    parameter logic [47:0] DST_MAC   = 48'h40ac14dfbb66,
    parameter logic [47:0] SRC_MAC   = 48'he044e435dba6,
    parameter int          IFG_BYTES = 12,
    parameter int          MAX_LEN   = 1500,
    parameter logic [15:0] VLAN_TCI  = 16'h0001
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [N_CH-1:0]    ch_rdy,
    input  logic [N_CH*11-1:0] ch_len,
    input  logic [N_CH*16-1:0] ch_type,
    input  logic [N_CH*8-1:0]  ch_data,
    output logic [N_CH-1:0]    ch_ren,
    output logic [N_CH-1:0]    ch_done,
    output logic [N_CH-1:0]    ch_err,
    output logic               tx_en,
    output logic [7:0]         txd,
    output logic               busy
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef TX_VLAN_EN
    localparam logic [10:0] PAD_MIN = 11'd42;
`else
    localparam logic [10:0] PAD_MIN = 11'd46;
`endif
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
    localparam logic [31:0] VLAN_TAG = {16'h8100, VLAN_TCI};

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_VLAN, S_TYPE, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t        state, state_n;
    logic [10:0]   bcnt, bcnt_n;
    logic [IW-1:0] gnt, rr_ptr, pick;
    logic          found, grant, len_bad, accept, crc_en;
    logic [10:0]   len, pick_len, pad_last;
    logic [15:0]   etype;
    logic [31:0]   crc, crc_inv;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // First ready channel at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: defaults assigned before the loop so no path leaves found/pick unassigned (no latch).
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && ch_rdy[(int'(rr_ptr) + k) % N_CH]) begin
                found = 1'b1;
                pick  = IW'((int'(rr_ptr) + k) % N_CH);
            end
        end
    end

    assign pick_len = ch_len[11*int'(pick) +: 11];
    assign len_bad  = (pick_len == 11'd0) || (pick_len > MAX_L);
    assign grant    = arst_n && (state == S_IDLE) && found;
    assign accept   = grant && !len_bad;
    assign pad_last = PAD_MIN - len - 11'd1;
    assign crc_inv  = ~crc;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt + 11'd1;
        tx_en   = 1'b0;
        txd     = 8'h00;
        crc_en  = 1'b0;
        ch_ren  = '0;
        ch_done = '0;
        ch_err  = '0;
        case (state)
            S_IDLE: begin
                bcnt_n = '0;
                if (grant && len_bad) ch_err[pick] = 1'b1;
                if (accept) state_n = S_PRE;
            end
            S_PRE: begin
                tx_en = 1'b1;
                txd   = 8'h55;
                if (bcnt == 11'd6) begin state_n = S_SFD; bcnt_n = '0; end
            end
            S_SFD: begin
                tx_en   = 1'b1;
                txd     = 8'hD5;
                state_n = S_DST;
                bcnt_n  = '0;
            end
            S_DST: begin
                tx_en  = 1'b1;
                crc_en = 1'b1;
                txd    = DST_MAC[8*(5 - int'(bcnt[2:0])) +: 8];
                if (bcnt == 11'd5) begin state_n = S_SRC; bcnt_n = '0; end
            end
            S_SRC: begin
                tx_en  = 1'b1;
                crc_en = 1'b1;
                txd    = SRC_MAC[8*(5 - int'(bcnt[2:0])) +: 8];
                if (bcnt == 11'd5) begin
`ifdef TX_VLAN_EN
                    state_n = S_VLAN;
`else
                    state_n = S_TYPE;
`endif
                    bcnt_n = '0;
                end
            end
            S_VLAN: begin
                tx_en  = 1'b1;
                crc_en = 1'b1;
                txd    = VLAN_TAG[8*(3 - int'(bcnt[1:0])) +: 8];
                if (bcnt == 11'd3) begin state_n = S_TYPE; bcnt_n = '0; end
            end
            S_TYPE: begin
                tx_en  = 1'b1;
                crc_en = 1'b1;
                txd    = bcnt[0] ? etype[7:0] : etype[15:8];
                if (bcnt == 11'd1) begin state_n = S_PAY; bcnt_n = '0; end
            end
            S_PAY: begin
                tx_en       = 1'b1;
                crc_en      = 1'b1;
                txd         = ch_data[8*int'(gnt) +: 8];
                ch_ren[gnt] = 1'b1;
                if (bcnt == len - 11'd1) begin
                    state_n = (len < PAD_MIN) ? S_PAD : S_FCS;
                    bcnt_n  = '0;
                end
            end
            S_PAD: begin
                tx_en  = 1'b1;
                crc_en = 1'b1;
                if (bcnt == pad_last) begin state_n = S_FCS; bcnt_n = '0; end
            end
            S_FCS: begin
                tx_en = 1'b1;
                txd   = crc_inv[8*int'(bcnt[1:0]) +: 8];
                if (bcnt == 11'd3) begin state_n = S_IFG; bcnt_n = '0; end
            end
            S_IFG: begin
                if (bcnt == 11'd0) ch_done[gnt] = 1'b1;
                if (bcnt == IFG_LAST) begin state_n = S_IDLE; bcnt_n = '0; end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // CRC re-initialises at every grant so a frame truncated by reset leaves no residue.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state  <= S_IDLE;
            bcnt   <= '0;
            gnt    <= '0;
            rr_ptr <= '0;
            len    <= '0;
            etype  <= '0;
            crc    <= '1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_n;
            bcnt  <= bcnt_n;
            if (grant) begin
                gnt    <= pick;
                len    <= pick_len;
                etype  <= ch_type[16*int'(pick) +: 16];
                rr_ptr <= (pick == IW'(N_CH - 1)) ? '0 : pick + IW'(1);
                crc    <= '1;
            end else if (crc_en) begin
                crc <= crc_step(crc, txd);
            end
        end
    end
endmodule

// File: tb/tb_eth_tx_sched_encap.sv
// Self-checking bench for eth_tx_sched_encap: table-driven single frames plus hand-written
// sequences for length rejection, round-robin spacing and mid-frame reset.
module tb_eth_tx_sched_encap;
    localparam int          N_CH     = 2;
    localparam logic [47:0] DST_MAC  = 48'h40ac14dfbb66;
    localparam logic [47:0] SRC_MAC  = 48'he044e435dba6;
    localparam logic [15:0] VLAN_TCI = 16'h0001;
`ifdef TX_VLAN_EN
    localparam int PAD_MIN = 42;
`else
    localparam int PAD_MIN = 46;
`endif

    logic               clk = 1'b0;
    logic               arst_n;
    logic [N_CH-1:0]    ch_rdy;
    logic [N_CH*11-1:0] ch_len;
    logic [N_CH*16-1:0] ch_type;
    logic [N_CH*8-1:0]  ch_data;
    logic [N_CH-1:0]    ch_ren, ch_done, ch_err;
    logic               tx_en;
    logic [7:0]         txd;
    logic               busy;

    always #4 clk = ~clk;

    eth_tx_sched_encap dut (
        .clk(clk), .arst_n(arst_n), .ch_rdy(ch_rdy), .ch_len(ch_len), .ch_type(ch_type),
        .ch_data(ch_data), .ch_ren(ch_ren), .ch_done(ch_done), .ch_err(ch_err),
        .tx_en(tx_en), .txd(txd), .busy(busy)
    );

    function automatic logic [7:0] pat(input int ch, input int k);
        return 8'(k * 13 + ch * 97 + 5);
    endfunction

    // Show-ahead FIFO model: each channel serves pat(ch, idx) and advances on a pop.
    int pop_idx [N_CH] = '{default: 0};
    always @(posedge clk)
        for (int i = 0; i < N_CH; i++) if (ch_ren[i]) pop_idx[i] <= pop_idx[i] + 1;
    always_comb
        for (int i = 0; i < N_CH; i++) ch_data[8*i +: 8] = pat(i, pop_idx[i]);

    // Monitor, sampled on the falling edge.
    int         cyc = 0;
    logic       prev_en = 1'b0;
    logic [7:0] cap_q [$];
    int         rise_q [$], fall_q [$], done_q [$];
    int         ren_cnt [N_CH] = '{default: 0};
    int         done_cnt [N_CH] = '{default: 0};
    int         err_cnt [N_CH] = '{default: 0};
    always @(negedge clk) begin
        cyc++;
        if (tx_en) cap_q.push_back(txd);
        if (tx_en && !prev_en) rise_q.push_back(cyc);
        if (!tx_en && prev_en) fall_q.push_back(cyc - 1);
        prev_en = tx_en;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_ren[i]) ren_cnt[i]++;
            if (ch_done[i]) begin done_cnt[i]++; done_q.push_back(i); end
            if (ch_err[i]) err_cnt[i]++;
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    // Reference frame built independently, CRC computed bit-serially.
    logic [7:0]  exp_q [$];
    logic [31:0] m_crc;
    task automatic add_cov(input logic [7:0] b);
        logic fb;
        exp_q.push_back(b);
        for (int j = 0; j < 8; j++) begin
            fb    = m_crc[0] ^ b[j];
            m_crc = m_crc >> 1;
            if (fb) m_crc = m_crc ^ 32'hEDB88320;
        end
    endtask

    task automatic build_expected(input int ch, input int len, input logic [15:0] et, input int base);
        logic [31:0] fcs;
        exp_q.delete();
        m_crc = 32'hFFFFFFFF;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) add_cov(DST_MAC[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) add_cov(SRC_MAC[8*(5-i) +: 8]);
`ifdef TX_VLAN_EN
        add_cov(8'h81); add_cov(8'h00); add_cov(VLAN_TCI[15:8]); add_cov(VLAN_TCI[7:0]);
`endif
        add_cov(et[15:8]);
        add_cov(et[7:0]);
        for (int k = 0; k < len; k++) add_cov(pat(ch, base + k));
        for (int k = len; k < PAD_MIN; k++) add_cov(8'h00);
        fcs = ~m_crc;
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endtask

    task automatic run_frame(input int ch, input int len, input logic [15:0] et, input bit bad,
                             input int exp_cycles, input string tag);
        int cap0, ren0, done0, err0, base, n, mism, t;
        logic [31:0] fcs_act, fcs_exp;
        cap0 = cap_q.size(); ren0 = ren_cnt[ch]; done0 = done_cnt[ch]; err0 = err_cnt[ch];
        base = pop_idx[ch];
        @(posedge clk); #1;
        ch_len[11*ch +: 11]  = 11'(len);
        ch_type[16*ch +: 16] = et;
        ch_rdy[ch]           = 1'b1;
        @(posedge clk); #1;
        ch_rdy[ch] = 1'b0;
        t = 0;
        while (busy && t < 4000) begin @(posedge clk); #1; t++; end
        check({tag, " finish"}, busy, 0);
        @(negedge clk);
        n = cap_q.size() - cap0;
        check({tag, " tx_en cycles"}, n, exp_cycles);
        check({tag, " ch_err pulses"}, err_cnt[ch] - err0, bad ? 1 : 0);
        check({tag, " ch_ren pops"}, ren_cnt[ch] - ren0, bad ? 0 : len);
        check({tag, " ch_done pulses"}, done_cnt[ch] - done0, bad ? 0 : 1);
        if (!bad) begin
            build_expected(ch, len, et, base);
            mism = 0;
            for (int i = 0; i < exp_q.size() - 4; i++)
                if (i >= n || cap_q[cap0 + i] !== exp_q[i]) mism++;
            check({tag, " header/payload byte errors"}, mism, 0);
            fcs_act = '0;
            fcs_exp = '0;
            for (int i = 0; i < 4; i++) begin
                fcs_exp[8*i +: 8] = exp_q[exp_q.size() - 4 + i];
                if (n >= 4) fcs_act[8*i +: 8] = cap_q[cap0 + n - 4 + i];
            end
            check({tag, " fcs"}, fcs_act, fcs_exp);
        end
    endtask

    typedef struct {
        int          ch;
        int          len;
        logic [15:0] etype;
        bit          bad;
        int          exp_cycles;
    } vec_t;
    vec_t vecs [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        int r0, f0, d0, t, n, base, ren0, done0;

`ifdef TX_VLAN_EN
        vecs.push_back('{0, 64,   16'h0800, 1'b0, 94});
        vecs.push_back('{1, 1,    16'h88b5, 1'b0, 72});
        vecs.push_back('{0, 46,   16'h0806, 1'b0, 76});
        vecs.push_back('{1, 45,   16'h86dd, 1'b0, 75});
        vecs.push_back('{0, 42,   16'h0800, 1'b0, 72});
        vecs.push_back('{1, 10,   16'h0800, 1'b0, 72});
        vecs.push_back('{0, 1500, 16'h0800, 1'b0, 1530});
`else
        vecs.push_back('{0, 64,   16'h0800, 1'b0, 90});
        vecs.push_back('{1, 1,    16'h88b5, 1'b0, 72});
        vecs.push_back('{0, 46,   16'h0806, 1'b0, 72});
        vecs.push_back('{1, 45,   16'h86dd, 1'b0, 72});
        vecs.push_back('{0, 42,   16'h0800, 1'b0, 72});
        vecs.push_back('{1, 10,   16'h0800, 1'b0, 72});
        vecs.push_back('{0, 1500, 16'h0800, 1'b0, 1526});
`endif
        vecs.push_back('{1, 1501, 16'h0800, 1'b1, 0});
        vecs.push_back('{0, 0,    16'h0800, 1'b1, 0});

        // Reset: outputs stay 0 even with a (bad) channel ready.
        arst_n = 1'b0; ch_rdy = '0; ch_len = '0; ch_type = '0;
        repeat (2) @(posedge clk);
        #1 ch_rdy = 2'b01;
        @(negedge clk);
        check("reset tx_en", tx_en, 0);
        check("reset txd", txd, 0);
        check("reset busy", busy, 0);
        check("reset ch_err", ch_err, 0);
        check("reset ch_ren", ch_ren, 0);
        check("reset ch_done", ch_done, 0);
        @(posedge clk); #1;
        ch_rdy = '0;
        arst_n = 1'b1;

        // Both channels bad: ch0 rejected first (rr_ptr=0), then ch1.
        r0 = rise_q.size();
        @(posedge clk); #1;
        ch_len = {11'd1501, 11'd0};
        ch_rdy = 2'b11;
        @(negedge clk);
        check("bad-len first ch_err", ch_err, 2'b01);
        check("bad-len first ch_ren", ch_ren, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bad-len second ch_err", ch_err, 2'b10);
        @(posedge clk); #1;
        ch_rdy = '0;
        repeat (4) @(posedge clk);
        #1;
        check("bad-len busy", busy, 0);
        check("bad-len tx_en bursts", rise_q.size() - r0, 0);
        check("bad-len ch0 errs", err_cnt[0], 1);
        check("bad-len ch1 errs", err_cnt[1], 1);
        check("bad-len pops", ren_cnt[0] + ren_cnt[1], 0);

        foreach (vecs[i])
            run_frame(vecs[i].ch, vecs[i].len, vecs[i].etype, vecs[i].bad, vecs[i].exp_cycles,
                      $sformatf("vec%0d", i));

        // Round robin from rr_ptr=0 with both channels continuously ready.
        @(posedge clk); #1 arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        r0 = rise_q.size(); f0 = fall_q.size(); d0 = done_q.size();
        ren0 = ren_cnt[0] + ren_cnt[1];
        @(posedge clk); #1;
        ch_len = {11'd20, 11'd10};
        ch_rdy = 2'b11;
        t = 0;
        while (done_q.size() < d0 + 3 && t < 2000) begin @(posedge clk); #1; t++; end
        ch_rdy = '0;
        t = 0;
        while (busy && t < 200) begin @(posedge clk); #1; t++; end
        @(negedge clk);
        check("rr done count", done_q.size() - d0, 3);
        check("rr burst count", rise_q.size() - r0, 3);
        check("rr pops", ren_cnt[0] + ren_cnt[1] - ren0, 40);
        if (done_q.size() >= d0 + 3) begin
            check("rr order 0", done_q[d0], 0);
            check("rr order 1", done_q[d0 + 1], 1);
            check("rr order 2", done_q[d0 + 2], 0);
        end
        if (rise_q.size() >= r0 + 3 && fall_q.size() >= f0 + 2) begin
            check("rr gap 1", rise_q[r0 + 1] - fall_q[f0] - 1, 13);
            check("rr gap 2", rise_q[r0 + 2] - fall_q[f0 + 1] - 1, 13);
        end

        // Reset asserted during payload byte 20 of a 100-byte frame.
        base = pop_idx[0]; ren0 = ren_cnt[0]; done0 = done_cnt[0];
        @(posedge clk); #1;
        ch_len[10:0] = 11'd100;
        ch_type[15:0] = 16'h0800;
        ch_rdy[0] = 1'b1;
        @(posedge clk); #1;
        ch_rdy[0] = 1'b0;
        n = 0;
        t = 0;
        while (n < 21 && t < 400) begin
            @(posedge clk); #1;
            if (ch_ren[0]) n++;
            t++;
        end
        check("abort reached byte 20", n, 21);
        check("abort byte 20 txd", txd, pat(0, base + 20));
        check("abort tx_en before reset", tx_en, 1);
        #1 arst_n = 1'b0;
        #1;
        check("abort tx_en async", tx_en, 0);
        check("abort busy async", busy, 0);
        check("abort ch_ren async", ch_ren, 0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort no ch_done", done_cnt[0] - done0, 0);
        check("abort pops", ren_cnt[0] - ren0, 20);
        run_frame(0, 30, 16'h0800, 1'b0, 72, "restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
